// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: state encoding, default widths
// and the width of the request timeout count.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int CNT_W      = 8;

endpackage

// File: rtl/lsu_timeout_counter.sv
// Counts REQ cycles spent without an acknowledge; flags the terminal count
// TIMEOUT-1 so the caller can abandon the request.
module lsu_timeout_counter
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count_r;

    // Count register; clear wins over enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign terminal = (count_r == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: turns read/write enables into a req/ack
// transaction with data memory and stalls the pipeline until it completes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_en,
    input  logic              mem_write_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              stall,
    output logic              access_fault,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack
);

    lsu_state_e state_r;
    lsu_state_e state_s;
    logic       one_en_s;
    logic       both_en_s;
    logic       timeout_s;
    logic       cnt_clear_s;
    logic       cnt_enable_s;

    assign one_en_s  = mem_read_en ^ mem_write_en;
    assign both_en_s = mem_read_en & mem_write_en;

    assign cnt_clear_s  = (state_r != REQ) || dmem_ack || timeout_s;
    assign cnt_enable_s = (state_r == REQ) && !dmem_ack;

    lsu_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear_s),
        .enable   (cnt_enable_s),
        .terminal (timeout_s)
    );

    // Next-state and stall; stall rises in the issuing cycle so the
    // upstream registers freeze before the request even starts.
    always_comb begin
        state_s = state_r;
        stall   = 1'b0;
        case (state_r)
            IDLE: begin
                if (one_en_s) begin
                    stall   = 1'b1;
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dmem_ack || timeout_s) begin
                    state_s = DONE;
                end else begin
                    state_s = REQ;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    assign dmem_req = (state_r == REQ);

    // State, request latches and the registered result/pulse outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            load_data    <= {DATA_W{1'b0}};
            load_valid   <= 1'b0;
            access_fault <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= {ADDR_W{1'b0}};
            dmem_wdata   <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_s;
            load_valid   <= 1'b0;
            access_fault <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (one_en_s) begin
                        dmem_we    <= mem_write_en;
                        dmem_addr  <= addr;
                        dmem_wdata <= store_data;
                    end else if (both_en_s) begin
                        access_fault <= 1'b1;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        if (!dmem_we) begin
                            load_data  <= dmem_rdata;
                            load_valid <= 1'b1;
                        end
                    end else if (timeout_s) begin
                        // A timed-out load must not leave stale data behind.
                        load_data    <= {DATA_W{1'b0}};
                        access_fault <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with hand-computed
// expectations; memory responses are driven cycle by cycle.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [15:0] addr;
    logic [15:0] store_data;
    logic [15:0] load_data;
    logic        load_valid;
    logic        stall;
    logic        access_fault;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;

    int checks = 0;
    int errors = 0;

    load_store_unit #(
        .DATA_W  (16),
        .ADDR_W  (16),
        .TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .addr         (addr),
        .store_data   (store_data),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .stall        (stall),
        .access_fault (access_fault),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge; inputs change here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; mem_read_en = 1'b0; mem_write_en = 1'b0;
        addr = 16'h0000; store_data = 16'h0000;
        dmem_rdata = 16'h0000; dmem_ack = 1'b0;
        next_cycle();
        next_cycle();
        settle();
        check_eq("rst_req",   {31'd0, dmem_req},     32'd0);
        check_eq("rst_stall", {31'd0, stall},        32'd0);
        check_eq("rst_ldata", {16'd0, load_data},    32'd0);
        check_eq("rst_fault", {31'd0, access_fault}, 32'd0);
        rst_n = 1'b1;
        next_cycle();

        // Read, zero wait states
        mem_read_en = 1'b1; addr = 16'h0040;
        settle();
        check_eq("rd0_stall_c0", {31'd0, stall},    32'd1);
        check_eq("rd0_req_c0",   {31'd0, dmem_req}, 32'd0);
        next_cycle();
        dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
        settle();
        check_eq("rd0_req_c1",   {31'd0, dmem_req},   32'd1);
        check_eq("rd0_addr_c1",  {16'd0, dmem_addr},  32'h0040);
        check_eq("rd0_we_c1",    {31'd0, dmem_we},    32'd0);
        check_eq("rd0_stall_c1", {31'd0, stall},      32'd1);
        check_eq("rd0_valid_c1", {31'd0, load_valid}, 32'd0);
        next_cycle();
        dmem_ack = 1'b0;
        settle();
        check_eq("rd0_valid_c2", {31'd0, load_valid}, 32'd1);
        check_eq("rd0_ldata_c2", {16'd0, load_data},  32'h0000BEEF);
        check_eq("rd0_stall_c2", {31'd0, stall},      32'd0);
        check_eq("rd0_req_c2",   {31'd0, dmem_req},   32'd0);
        next_cycle();
        mem_read_en = 1'b0;
        settle();
        check_eq("rd0_valid_c3", {31'd0, load_valid}, 32'd0);
        check_eq("rd0_ldata_c3", {16'd0, load_data},  32'h0000BEEF);

        // Write with 3 wait states: 4 REQ cycles, 5 stall cycles
        next_cycle();
        mem_write_en = 1'b1; addr = 16'h00F0; store_data = 16'h1234;
        settle();
        check_eq("wr_stall_c0", {31'd0, stall}, 32'd1);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            dmem_ack = (k == 3);
            settle();
            check_eq($sformatf("wr_req_%0d", k),   {31'd0, dmem_req},   32'd1);
            check_eq($sformatf("wr_we_%0d", k),    {31'd0, dmem_we},    32'd1);
            check_eq($sformatf("wr_wdata_%0d", k), {16'd0, dmem_wdata}, 32'h1234);
            check_eq($sformatf("wr_addr_%0d", k),  {16'd0, dmem_addr},  32'h00F0);
            check_eq($sformatf("wr_stall_%0d", k), {31'd0, stall},      32'd1);
            next_cycle();
        end
        dmem_ack = 1'b0;
        settle();
        check_eq("wr_done_req",   {31'd0, dmem_req},   32'd0);
        check_eq("wr_done_stall", {31'd0, stall},      32'd0);
        check_eq("wr_done_valid", {31'd0, load_valid}, 32'd0);
        check_eq("wr_done_ldata", {16'd0, load_data},  32'h0000BEEF);
        check_eq("wr_done_fault", {31'd0, access_fault}, 32'd0);
        next_cycle();
        mem_write_en = 1'b0;

        // Timeout: read with no ack, 15 REQ cycles then fault
        next_cycle();
        mem_read_en = 1'b1; addr = 16'h0123;
        settle();
        check_eq("to_stall_c0", {31'd0, stall}, 32'd1);
        next_cycle();
        for (int k = 0; k < 15; k++) begin
            settle();
            check_eq($sformatf("to_req_%0d", k),   {31'd0, dmem_req},     32'd1);
            check_eq($sformatf("to_fault_%0d", k), {31'd0, access_fault}, 32'd0);
            next_cycle();
        end
        settle();
        check_eq("to_done_req",   {31'd0, dmem_req},     32'd0);
        check_eq("to_done_fault", {31'd0, access_fault}, 32'd1);
        check_eq("to_done_ldata", {16'd0, load_data},    32'd0);
        check_eq("to_done_valid", {31'd0, load_valid},   32'd0);
        check_eq("to_done_stall", {31'd0, stall},        32'd0);
        next_cycle();
        mem_read_en = 1'b0;
        settle();
        check_eq("to_idle_fault", {31'd0, access_fault}, 32'd0);
        check_eq("to_idle_req",   {31'd0, dmem_req},     32'd0);

        // Illegal request: both enables high
        next_cycle();
        mem_read_en = 1'b1; mem_write_en = 1'b1; addr = 16'h0200;
        settle();
        check_eq("ill_stall_c0", {31'd0, stall},        32'd0);
        check_eq("ill_fault_c0", {31'd0, access_fault}, 32'd0);
        next_cycle();
        mem_read_en = 1'b0; mem_write_en = 1'b0;
        settle();
        check_eq("ill_fault_c1", {31'd0, access_fault}, 32'd1);
        check_eq("ill_req_c1",   {31'd0, dmem_req},     32'd0);
        check_eq("ill_stall_c1", {31'd0, stall},        32'd0);
        next_cycle();
        settle();
        check_eq("ill_fault_c2", {31'd0, access_fault}, 32'd0);
        check_eq("ill_req_c2",   {31'd0, dmem_req},     32'd0);

        // Back-to-back loads with enables held through DONE
        mem_read_en = 1'b1; addr = 16'h0050;
        next_cycle();
        dmem_ack = 1'b1; dmem_rdata = 16'h1111;
        settle();
        check_eq("b2b_req1",  {31'd0, dmem_req},  32'd1);
        check_eq("b2b_addr1", {16'd0, dmem_addr}, 32'h0050);
        next_cycle();
        dmem_ack = 1'b0;
        settle();
        check_eq("b2b_done1_req",   {31'd0, dmem_req},   32'd0);
        check_eq("b2b_done1_stall", {31'd0, stall},      32'd0);
        check_eq("b2b_done1_ldata", {16'd0, load_data},  32'h1111);
        next_cycle();
        addr = 16'h0041;
        settle();
        check_eq("b2b_issue2_stall", {31'd0, stall},    32'd1);
        check_eq("b2b_issue2_req",   {31'd0, dmem_req}, 32'd0);
        next_cycle();
        dmem_ack = 1'b1; dmem_rdata = 16'h2222;
        settle();
        check_eq("b2b_req2",  {31'd0, dmem_req},  32'd1);
        check_eq("b2b_addr2", {16'd0, dmem_addr}, 32'h0041);
        next_cycle();
        dmem_ack = 1'b0;
        settle();
        check_eq("b2b_done2_valid", {31'd0, load_valid}, 32'd1);
        check_eq("b2b_done2_ldata", {16'd0, load_data},  32'h2222);
        check_eq("b2b_done2_stall", {31'd0, stall},      32'd0);
        next_cycle();
        mem_read_en = 1'b0;
        settle();
        check_eq("b2b_after_req", {31'd0, dmem_req}, 32'd0);

        // Reset during the second REQ cycle, then a late ack
        next_cycle();
        mem_write_en = 1'b1; addr = 16'h0077; store_data = 16'h5A5A;
        next_cycle();
        settle();
        check_eq("rst_mid_req1", {31'd0, dmem_req}, 32'd1);
        next_cycle();
        rst_n = 1'b0;
        settle();
        check_eq("rst_mid_req2", {31'd0, dmem_req}, 32'd1);
        next_cycle();
        mem_write_en = 1'b0;
        settle();
        check_eq("rst_mid_req",   {31'd0, dmem_req},     32'd0);
        check_eq("rst_mid_we",    {31'd0, dmem_we},      32'd0);
        check_eq("rst_mid_addr",  {16'd0, dmem_addr},    32'd0);
        check_eq("rst_mid_wdata", {16'd0, dmem_wdata},   32'd0);
        check_eq("rst_mid_ldata", {16'd0, load_data},    32'd0);
        check_eq("rst_mid_valid", {31'd0, load_valid},   32'd0);
        check_eq("rst_mid_fault", {31'd0, access_fault}, 32'd0);
        rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 16'h9999;
        next_cycle();
        dmem_ack = 1'b0;
        settle();
        check_eq("late_ack_valid", {31'd0, load_valid},   32'd0);
        check_eq("late_ack_ldata", {16'd0, load_data},    32'd0);
        check_eq("late_ack_req",   {31'd0, dmem_req},     32'd0);
        check_eq("late_ack_fault", {31'd0, access_fault}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage load/store engine of the 16-bit custom processor.
- Turns the control unit's read/write enables and the ALU result (used as the address) into a request/acknowledge transaction with data memory.
- Stalls the pipeline until the transaction completes.
- Returns the loaded word on load_data, which drives the Mem_Data input of the writeback select mux.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, word address width.
- TIMEOUT, 15, maximum number of REQ cycles without dmem_ack before a fault; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_read_en  in  1  load requested by the instruction in the MEM stage.
- mem_write_en  in  1  store requested by the instruction in the MEM stage.
- addr  in  ADDR_W  effective address (ALU result).
- store_data  in  DATA_W  store operand.
- load_data  out  DATA_W  registered load result; feeds writeback mux Mem_Data.
- load_valid  out  1  one-cycle pulse; load_data updated this cycle.
- stall  out  1  freeze pipeline registers upstream of MEM.
- access_fault  out  1  one-cycle pulse on an illegal request or a timeout.
- dmem_req  out  1  request to data memory.
- dmem_we  out  1  1 = write, 0 = read; valid while dmem_req is high.
- dmem_addr  out  ADDR_W  registered address.
- dmem_wdata  out  DATA_W  registered write data.
- dmem_rdata  in  DATA_W  read data; sampled when dmem_ack is high.
- dmem_ack  in  1  memory completion, single cycle.

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - Reset is synchronous and active-low via rst_n; no asynchronous reset.
  - While rst_n=0, on the next edge every output goes to 0 (load_data=0, dmem_addr=0, dmem_wdata=0), state goes to IDLE and the timeout count goes to 0.
- States: IDLE, REQ, DONE.
- IDLE:
  - Exactly one of mem_read_en / mem_write_en high: latch addr, store_data and we=mem_write_en; next state REQ; stall=1 combinationally this cycle.
  - Both high: no request; access_fault=1 registered the next cycle; stay IDLE; stall=0.
  - Neither high: idle, stall=0.
- REQ:
  - dmem_req=1; dmem_addr, dmem_wdata and dmem_we come from the latched registers and stay stable for the whole request; stall=1.
  - dmem_ack=1: for a read, capture dmem_rdata into load_data; go to DONE; clear the count.
  - dmem_ack=0: increment the count. When count reaches TIMEOUT-1 and ack is still 0, go to DONE with the fault flag set.
- DONE:
  - dmem_req=0, stall=0.
  - load_valid=1 only for a successful read.
  - access_fault=1 for a timeout; load_data is then forced to 0.
  - Enables are ignored in DONE; the still-asserted enables of the finishing instruction must not re-issue. Next state is always IDLE.
- Latency:
  - Zero-wait memory (ack in the first REQ cycle): enable at cycle 0, REQ at cycle 1, DONE/load_valid at cycle 2. That is 2 stall cycles.
  - Each wait cycle adds one stall cycle.
- Other rules:
  - load_data holds its value across stores, faults-free idle cycles and stalls; it changes only on a successful read, a timeout, or reset.
  - dmem_ack outside REQ is ignored.
  - Address arithmetic is none; the full ADDR_W is passed through and there is no alignment check (word-addressed).
  - Reset in REQ: dmem_req drops on that edge, no load_valid, no fault.

Decomposition:
- Shared package lsu_pkg holds:
  - state encoding IDLE=2'd0, REQ=2'd1, DONE=2'd2;
  - DATA_W and ADDR_W defaults;
  - the width of the timeout count, 8 bits.
- One sub-module, lsu_timeout_counter (clear, enable, terminal-count flag at TIMEOUT-1). Everything else stays in load_store_unit.

Test Plan:
- Read, zero wait: mem_read_en=1, addr=16'h0040, ack in the first REQ cycle with rdata=16'hBEEF -> dmem_req high exactly 1 cycle with dmem_addr=16'h0040 and dmem_we=0; load_valid at cycle 2 with load_data=16'hBEEF; stall high for cycles 0-1 only.
- Write, 3 wait states: mem_write_en=1, addr=16'h00F0, store_data=16'h1234, ack on the 4th REQ cycle -> dmem_we=1 and dmem_wdata=16'h1234 stable for 4 cycles; no load_valid; load_data unchanged; 5 stall cycles.
- Timeout with TIMEOUT=15: read, ack never asserted -> dmem_req high for 15 cycles, then access_fault pulse, load_data=0, return to IDLE.
- Illegal request: read and write enables both high -> no dmem_req; access_fault pulse one cycle later; stall stays 0.
- Back-to-back: enables held through DONE, then a new read at addr=16'h0041 -> exactly one request per instruction; second load returns its own rdata.
- Reset mid-transaction: rst_n=0 in the 2nd REQ cycle -> all outputs 0 next edge; a late ack after reset produces no load_valid.
